// File: rtl/frame_pkg.sv
// Shared types and elaboration-time helpers for the frame writer slice.
package frame_pkg;

  typedef enum logic {
    ST_SYNC,
    ST_ACTIVE
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_writer_bank_seq.sv
// Frame-buffer bank rotation: bank index plus its base address, stepped by one frame per advance.
module bank_seq
  import frame_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 2,
  parameter int unsigned FRAME_PIX = 8,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned BANK_W    = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              adv_i,
  output logic [BANK_W-1:0] bank_o,
  output logic [ADDR_W-1:0] base_o
);

  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ADDR_W-1:0] base_q, base_d;

  // Base is accumulated rather than computed as bank*FRAME_PIX.
  always_comb begin
    bank_d = bank_q;
    base_d = base_q;
    if (clr_i) begin
      bank_d = '0;
      base_d = '0;
    end else if (adv_i) begin
      if (bank_q == BANK_W'(NUM_BANKS - 1)) begin
        bank_d = '0;
        base_d = '0;
      end else begin
        bank_d = bank_q + BANK_W'(1);
        base_d = base_q + ADDR_W'(FRAME_PIX);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bank_q <= '0;
      base_q <= '0;
    end else begin
      bank_q <= bank_d;
      base_q <= base_d;
    end
  end

  assign bank_o = bank_q;
  assign base_o = base_q;

endmodule

// File: rtl/frame_writer.sv
// FIFO-to-BRAM frame writer: SOF alignment, short/long frame detection, multi-bank rotation.
module frame_writer
  import frame_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned FRAME_W    = 640,
  parameter int unsigned FRAME_H    = 480,
  parameter int unsigned NUM_BANKS  = 2,
  localparam int unsigned FRAME_PIX = FRAME_W * FRAME_H,
  localparam int unsigned ADDR_W    = max2(1, clog2(NUM_BANKS * FRAME_PIX)),
  localparam int unsigned BANK_W    = max2(1, clog2(NUM_BANKS))
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  i_rsof,
  input  logic                  i_empty,
  output logic                  o_rd,
  output logic                  o_wr,
  output logic [ADDR_W-1:0]     o_waddr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [BANK_W-1:0]     o_done_bank,
  output logic                  o_frame_done,
  output logic                  o_err_short,
  output logic                  o_err_long,
  output logic [15:0]           o_frame_cnt
);

  localparam int unsigned OFF_W = max2(1, clog2(FRAME_PIX));
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(FRAME_PIX - 1);

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [OFF_W-1:0]  wr_off;
  logic              do_wr, err_s, err_l, complete;
  logic [BANK_W-1:0] bank;
  logic [ADDR_W-1:0] base;

  assign o_rd = i_en & ~i_empty & ~i_flush;

  bank_seq #(
    .NUM_BANKS (NUM_BANKS),
    .FRAME_PIX (FRAME_PIX),
    .ADDR_W    (ADDR_W),
    .BANK_W    (BANK_W)
  ) u_bank_seq (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .clr_i  (i_flush),
    .adv_i  (complete),
    .bank_o (bank),
    .base_o (base)
  );

  // An SOF pixel always lands at offset 0, whether it starts, restarts or follows a frame.
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    do_wr   = 1'b0;
    wr_off  = '0;
    err_s   = 1'b0;
    err_l   = 1'b0;
    if (i_flush) begin
      state_d = ST_SYNC;
      off_d   = '0;
    end else if (o_rd) begin
      unique case (state_q)
        ST_SYNC: do_wr = i_rsof;
        ST_ACTIVE: begin
          if (off_q == '0) begin
            if (i_rsof) begin
              do_wr = 1'b1;
            end else begin
              err_l   = 1'b1;
              state_d = ST_SYNC;
            end
          end else begin
            do_wr = 1'b1;
            if (i_rsof) err_s = 1'b1;
            else        wr_off = off_q;
          end
        end
        default: state_d = ST_SYNC;
      endcase
    end
    complete = do_wr && (wr_off == LAST_OFF);
    if (do_wr) begin
      state_d = ST_ACTIVE;
      off_d   = complete ? '0 : wr_off + OFF_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_SYNC;
      off_q        <= '0;
      o_wr         <= 1'b0;
      o_waddr      <= '0;
      o_wdata      <= '0;
      o_done_bank  <= '0;
      o_frame_done <= 1'b0;
      o_err_short  <= 1'b0;
      o_err_long   <= 1'b0;
      o_frame_cnt  <= '0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      o_wr         <= do_wr;
      o_frame_done <= complete;
      o_err_short  <= err_s;
      o_err_long   <= err_l;
      if (do_wr) begin
        o_waddr <= base + ADDR_W'(wr_off);
        o_wdata <= i_rdata;
      end
      if (complete) begin
        o_done_bank <= bank;
        o_frame_cnt <= o_frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// Randomized bench for frame_writer (NUM_BANKS=2 and NUM_BANKS=1 side by side) against a frame-level model.
module tb_frame_writer;

  localparam int FP = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, flush = 1'b0, sof = 1'b0, empty = 1'b1;
  logic [11:0] rdata = '0;

  logic        rd0, wr0, dbank0, fdone0, es0, el0;
  logic [3:0]  waddr0;
  logic [11:0] wdata0;
  logic [15:0] cnt0;
  logic        rd1, wr1, dbank1, fdone1, es1, el1;
  logic [2:0]  waddr1;
  logic [11:0] wdata1;
  logic [15:0] cnt1;

  int n_checks = 0;
  int n_errors = 0;

  frame_writer #(.DATA_WIDTH(12), .FRAME_W(4), .FRAME_H(2), .NUM_BANKS(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_flush(flush), .i_rdata(rdata), .i_rsof(sof),
    .i_empty(empty), .o_rd(rd0), .o_wr(wr0), .o_waddr(waddr0), .o_wdata(wdata0),
    .o_done_bank(dbank0), .o_frame_done(fdone0), .o_err_short(es0), .o_err_long(el0),
    .o_frame_cnt(cnt0)
  );

  frame_writer #(.DATA_WIDTH(12), .FRAME_W(4), .FRAME_H(2), .NUM_BANKS(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_flush(flush), .i_rdata(rdata), .i_rsof(sof),
    .i_empty(empty), .o_rd(rd1), .o_wr(wr1), .o_waddr(waddr1), .o_wdata(wdata1),
    .o_done_bank(dbank1), .o_frame_done(fdone1), .o_err_short(es1), .o_err_long(el1),
    .o_frame_cnt(cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level model: synced flag, pixels written so far, bank, counters.
  int          nbs[2] = '{2, 1};
  bit          m_sync[2];
  int          m_pos[2], m_bank[2], m_cnt[2], m_dbank[2];
  bit          x_wr[2], x_done[2], x_es[2], x_el[2];
  int          x_addr[2];
  logic [11:0] x_data;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sync[i] = 0; m_pos[i] = 0; m_bank[i] = 0; m_cnt[i] = 0; m_dbank[i] = 0;
      x_wr[i] = 0; x_done[i] = 0; x_es[i] = 0; x_el[i] = 0; x_addr[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit pop, input bit fl, input bit s,
                            input logic [11:0] d);
    int p;
    p = -1;
    x_wr[i] = 0; x_done[i] = 0; x_es[i] = 0; x_el[i] = 0;
    if (fl) begin
      m_sync[i] = 0; m_pos[i] = 0; m_bank[i] = 0;
    end else if (pop) begin
      if (!m_sync[i]) begin
        if (s) p = 0;
      end else if (m_pos[i] == 0) begin
        if (s) p = 0;
        else begin x_el[i] = 1; m_sync[i] = 0; end
      end else if (s) begin
        x_es[i] = 1; p = 0;
      end else begin
        p = m_pos[i];
      end
      if (p >= 0) begin
        x_wr[i] = 1; x_addr[i] = m_bank[i] * FP + p; x_data = d;
        m_sync[i] = 1; m_pos[i] = p + 1;
        if (p == FP - 1) begin
          x_done[i] = 1; m_dbank[i] = m_bank[i];
          m_cnt[i] = (m_cnt[i] + 1) % 65536;
          m_bank[i] = (m_bank[i] + 1) % nbs[i];
          m_pos[i] = 0;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    check("wr", 32'(wr0), 32'(x_wr[0]));
    if (x_wr[0]) begin
      check("waddr", 32'(waddr0), 32'(x_addr[0]));
      check("wdata", 32'(wdata0), 32'(x_data));
    end
    check("frame_done", 32'(fdone0), 32'(x_done[0]));
    check("err_short", 32'(es0), 32'(x_es[0]));
    check("err_long", 32'(el0), 32'(x_el[0]));
    check("done_bank", 32'(dbank0), 32'(m_dbank[0]));
    check("frame_cnt", 32'(cnt0), 32'(m_cnt[0]));
    check("nb1_wr", 32'(wr1), 32'(x_wr[1]));
    if (x_wr[1]) begin
      check("nb1_waddr", 32'(waddr1), 32'(x_addr[1]));
      check("nb1_wdata", 32'(wdata1), 32'(x_data));
    end
    check("nb1_frame_done", 32'(fdone1), 32'(x_done[1]));
    check("nb1_err_short", 32'(es1), 32'(x_es[1]));
    check("nb1_err_long", 32'(el1), 32'(x_el[1]));
    check("nb1_done_bank", 32'(dbank1), 32'(m_dbank[1]));
    check("nb1_frame_cnt", 32'(cnt1), 32'(m_cnt[1]));
  endtask

  task automatic cyc(input bit e, input bit emp, input bit fl, input bit s, input logic [11:0] d);
    bit pop;
    @(negedge clk);
    en = e; empty = emp; flush = fl; sof = s; rdata = d;
    pop = e && !emp && !fl;
    #1;
    check("o_rd", 32'(rd0), 32'(pop));
    check("nb1_o_rd", 32'(rd1), 32'(pop));
    model_step(0, pop, fl, s, d);
    model_step(1, pop, fl, s, d);
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic push(input bit s);
    cyc(1, 0, 0, s, 12'($urandom));
  endtask

  task automatic idle();
    if ($urandom_range(0, 1) == 0) cyc(0, 0, 0, 1'($urandom), 12'($urandom));
    else                           cyc(1, 1, 0, 1'($urandom), 12'($urandom));
  endtask

  task automatic send_frame(input bit gaps);
    for (int k = 0; k < FP; k++) begin
      if (gaps) while ($urandom_range(0, 2) == 0) idle();
      push(k == 0);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_wr"}, 32'(wr0), 32'd0);
    check({tag, "_waddr"}, 32'(waddr0), 32'd0);
    check({tag, "_done_bank"}, 32'(dbank0), 32'd0);
    check({tag, "_frame_cnt"}, 32'(cnt0), 32'd0);
    check({tag, "_pulses"}, 32'({fdone0, es0, el0}), 32'd0);
    check({tag, "_nb1_frame_cnt"}, 32'(cnt1), 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Alignment: leading non-SOF pixels are dropped.
    repeat (3) push(0);
    send_frame(0);

    // Three back-to-back frames exercise bank wrap.
    repeat (3) send_frame(0);

    // Short frame: SOF on the 6th pixel restarts at offset 0.
    push(1);
    repeat (4) push(0);
    push(1);
    repeat (7) push(0);

    // Long frame: trailing non-SOF pixels dropped until the next SOF.
    repeat (3) push(0);
    send_frame(0);

    // Gaps inside frames.
    repeat (3) send_frame(1);

    // Flush at offset 4 with data pending.
    push(1);
    repeat (3) push(0);
    cyc(1, 0, 1, 0, 12'($urandom));
    send_frame(0);

    // Asynchronous reset mid-frame, asserted away from the clock edge.
    push(1);
    repeat (2) push(0);
    #2;
    en = 1'b0; empty = 1'b1;
    rst = 1'b1;
    #1;
    check_reset_state("async_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    send_frame(0);

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0,
          $urandom_range(0, 11) == 0, 12'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_writer.md
Name: frame_writer

Overview:
Parametrised successor to the single-bank FIFO-to-BRAM write controller. It pops pixels from a first-word-fall-through pixel FIFO and drives the write port of an external frame-buffer BRAM. It aligns writes to start-of-frame markers, detects short and long frames, and rotates across NUM_BANKS frame buffers, publishing the last completed bank to the display-side reader. It sits between the capture FIFO and the frame-buffer memory, entirely in the i_clk domain.

Parameters:
DATA_WIDTH, 12, pixel width in bits
FRAME_W, 640, pixels per line
FRAME_H, 480, lines per frame
NUM_BANKS, 2, number of frame buffers (1..4); 1 means overwrite in place
FRAME_PIX, FRAME_W*FRAME_H, localparam: pixels per frame
ADDR_W, clog2(NUM_BANKS*FRAME_PIX), localparam: write address width
BANK_W, max(1,clog2(NUM_BANKS)), localparam: bank index width

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  asynchronous, active-high reset
i_en  in  1  1 = popping allowed; 0 = pause with state held
i_flush  in  1  synchronous clear to SYNC, offset 0, bank 0; counters kept
i_rdata  in  DATA_WIDTH  FIFO head pixel, valid while i_empty=0
i_rsof  in  1  FIFO head start-of-frame flag, valid with i_rdata
i_empty  in  1  FIFO empty
o_rd  out  1  combinational pop: i_en & ~i_empty & ~i_flush
o_wr  out  1  registered BRAM write enable
o_waddr  out  ADDR_W  registered BRAM write address
o_wdata  out  DATA_WIDTH  registered BRAM write data
o_done_bank  out  BANK_W  bank index of the last fully written frame
o_frame_done  out  1  1-cycle pulse when a frame completes
o_err_short  out  1  1-cycle pulse: SOF arrived before the frame was complete
o_err_long  out  1  1-cycle pulse: pixel arrived after a complete frame without SOF
o_frame_cnt  out  16  count of completed frames; wraps at 2^16

Behaviour:
- Reset (async, i_rst=1): all registered outputs 0, state SYNC, offset 0, bank 0, base 0.
- Pop P occurs in cycle N. Any resulting write appears in cycle N+1 as o_wr=1, o_waddr=base+offset, o_wdata=P. Each pop yields at most one write. Dropped pops yield o_wr=0.
- State SYNC:
  - Pop with sof=0: pixel dropped.
  - Pop with sof=1: write at offset 0; offset becomes 1; go to ACTIVE.
- State ACTIVE, offset>0:
  - Pop with sof=0: write; offset increments.
  - Pop with sof=1: o_err_short pulses. Pixel is written at offset 0 of the same bank; offset becomes 1; the frame restarts.
- Frame completion: the write at offset FRAME_PIX-1 completes the frame. In the same cycle as that o_wr:
  - o_frame_done pulses;
  - o_done_bank is set to the current bank;
  - o_frame_cnt increments.
  - Then bank advances: wraps NUM_BANKS-1 to 0, base returns to 0. Otherwise base += FRAME_PIX; no multiplier.
  - Offset becomes 0; state stays ACTIVE.
- State ACTIVE, offset 0 (after completion):
  - Pop with sof=1: write normally.
  - Pop with sof=0: o_err_long pulses; pixel dropped; go to SYNC.
- Pause: i_en=0 or i_empty=1 means no pop; state, offset and bank are held; o_wr=0 next cycle. Gaps of any length inside a frame are legal.
- i_flush=1 has priority over a pop:
  - o_rd=0;
  - next cycle o_wr=0, state SYNC, offset 0, bank 0, base 0;
  - o_done_bank and o_frame_cnt unchanged;
  - error and done pulses suppressed.
- i_rst mid-frame: immediate clear; the partial frame is abandoned and not reported.
- Offset counter width: clog2(FRAME_PIX). Its compare uses FRAME_PIX-1 exactly, with no power-of-2 assumption.

Decomposition:
- Shared package frame_pkg: state encoding (ST_SYNC, ST_ACTIVE); a helper function for clog2 and max.
- One natural sub-module: bank_seq, which holds the bank index, base address and wrap logic, advanced by a single "advance" strobe.

Test Plan:
Use FRAME_W=4, FRAME_H=2 (FRAME_PIX=8), NUM_BANKS=2, unless stated.
1. Reset: assert i_rst asynchronously mid-cycle -> o_wr, o_waddr, o_done_bank, o_frame_cnt and all pulses read 0 immediately.
2. Alignment: 3 pixels with sof=0, then an 8-pixel frame starting with sof=1 -> 11 o_rd pulses; o_wr only for the 8 frame pixels at addr 0..7 with matching data; o_frame_done on the addr-7 write; o_done_bank=0; o_frame_cnt=1.
3. Banking and wrap: three back-to-back frames -> addresses 0..7, 8..15, 0..7; o_done_bank 0,1,0; o_frame_cnt=3. Repeat with NUM_BANKS=1 -> always 0..7.
4. Short frame: sof on the 6th pixel -> o_err_short pulses once; that pixel is written at addr 0; the frame then completes at addr 7.
5. Long frame: a 9th pixel with sof=0 after completion -> o_err_long pulses; it and following sof=0 pixels are dropped (no o_wr) until the next sof, which is written at addr 8.
6. Gaps and flush:
   - random i_empty/i_en gaps inside a frame -> identical address/data sequence;
   - i_flush at offset 4 with i_empty=0 -> o_rd=0 that cycle; the next sof frame is written at addr 0; o_frame_cnt is unchanged.
